mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the dual-port data RAM (ram): turns RISC-V load/store requests into ADRR_R/ENABLE_R reads and ADRR_W/ENABLE_W/Q_W writes.
//  Handles byte/half/word sizing, sign/zero extension, sub-word stores by read-modify-write, and misalignment detection.
//  Sits between the core's LSU stage and ram.
//  One request in flight at a time.
// PARAMETERS
//  addr_width  10  RAM word-address width (matches ram.addr_width)
//  data_width  32  RAM word width; fixed at 32 for RV32 lane logic
// PORTS
//  CLK         in   1               single clock; all state updates on posedge
//  RESET       in   1               synchronous, active-high
//  REQ_VALID   in   1               request present
//  REQ_READY   out  1               unit idle, request accepted when VALID&&READY at posedge
//  REQ_WE      in   1               1=store, 0=load
//  REQ_SIZE    in   2               00 byte, 01 half, 10 word; 11 treated as misaligned
//  REQ_UNSIGNED in  1               loads: 1=zero-extend, 0=sign-extend
//  REQ_ADDR    in   addr_width+2    byte address; word index = REQ_ADDR[addr_width+1:2]
//  REQ_WDATA   in   32              store data, right-aligned
//  RSP_VALID   out  1               one-cycle pulse, request complete
//  RSP_RDATA   out  32              extended load data (0 for stores/errors)
//  RSP_ERR     out  1               misaligned access, no RAM traffic issued
//  ADRR_R      out  addr_width      RAM read word address
//  ENABLE_R    out  1               RAM read enable
//  Q_R         in   32              RAM read data, valid the cycle after ENABLE_R is sampled
//  ADRR_W      out  addr_width      RAM write word address
//  ENABLE_W    out  1               RAM write enable
//  Q_W         out  32              RAM write data
// BEHAVIOUR
//  All outputs registered. Reset: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, ENABLE_R=0, ENABLE_W=0, ADRR_R=0, ADRR_W=0, Q_W=0.
//  FSM states: IDLE, RD, RD_WAIT, WR, RSP. REQ_READY=1 only in IDLE.
//  ADRR_*/Q_W hold their last value when the matching enable is low.
//  Misaligned: half with ADDR[0]=1, word with ADDR[1:0]!=0, or SIZE=11.
//   IDLE->RSP. RSP_ERR=1 in cycle k+1 (k = accept cycle). ENABLE_R and ENABLE_W never asserted.
//  Load: IDLE->RD (ENABLE_R=1 for one cycle) ->RD_WAIT (capture Q_R, extract lane) ->RSP. RSP_VALID in cycle k+3.
//  Word store: IDLE->WR (ENABLE_W=1, Q_W=REQ_WDATA for one cycle) ->RSP. RSP_VALID in k+2.
//  Byte/half store: IDLE->RD->RD_WAIT (merge REQ_WDATA lane into Q_R) ->WR->RSP. RSP_VALID in k+4.
//   Untouched bytes are preserved exactly.
//  Lanes: byte = ADDR[1:0]*8; half = ADDR[1]*16. Extension per REQ_UNSIGNED. Word loads ignore REQ_UNSIGNED.
//  RSP->IDLE unconditionally. No response backpressure. Next accept is possible in the cycle after RSP.
//  ENABLE_R and ENABLE_W are never high in the same cycle.
//  Request fields are latched at accept. Input changes after accept have no effect.
//  Reset mid-operation: next state IDLE, no RSP_VALID for the aborted request.
//   A write whose ENABLE_W cycle coincides with RESET=1 still commits in the RAM (the RAM is not reset).
//   RMW aborted before WR leaves memory unchanged.
// STRUCTURE
//  mem_pkg: typedef enum size_t {SZ_B, SZ_H, SZ_W}; typedef enum state_t; functions is_misaligned(), lane_extract(), lane_merge().
//  Sub-module mem_lane_align (combinational): inputs word, addr[1:0], size, unsigned, wdata; outputs extended load data and merged store word.
//  Instantiated once. FSM and registers in mem_access_unit.
// TESTING
//  Bench instantiates mem_access_unit + ram (addr_width=10), CLK period 20 ns, RESET high 2 cycles.
//  1 SW 0xDEADBEEF @0x008 -> ENABLE_W=1 one cycle, ADRR_W=2, Q_W=0xDEADBEEF; RSP_VALID at k+2, ERR=0.
//  2 LB @0x00B signed -> RSP_RDATA=0xFFFFFFDE at k+3. LBU @0x00B -> 0x000000DE. LH @0x00A -> 0xFFFFDEAD. LW @0x008 -> 0xDEADBEEF.
//  3 SB 0x55 @0x009 -> ENABLE_R with ADRR_R=2, then ENABLE_W with Q_W=0xDEAD55EF; RSP at k+4. Follow-up LW @0x008 -> 0xDEAD55EF.
//  4 LW @0x006, SH @0x003 -> RSP_ERR=1 at k+1, RSP_RDATA=0, no ENABLE_R/ENABLE_W pulse; RAM word 1 unchanged.
//  5 SH 0x1234 @0x00A with RESET=1 during RD_WAIT -> no ENABLE_W, no RSP_VALID, REQ_READY=1 next cycle; LW @0x008 still 0xDEAD55EF.
//  6 Back-to-back: REQ_VALID held with 4 alternating SW/LW to 0x3FC -> each accepted only in IDLE, responses in order, data matches.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and lane helpers for the RAM load/store unit
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RSP     = 3'd4
  } state_t;

  // Size 11 has no legal encoding, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] addr,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {addr, 3'b000});
    h = 16'(word >> {addr[1], 4'b0000});
    case (size)
      SZ_B:    res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Drop the low bytes of wdata into the addressed lane, keeping all other bytes.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] addr,
                                             input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      SZ_B: begin
        mask = 32'h0000_00FF << {addr, 3'b000};
        ins  = {24'h0, wdata[7:0]} << {addr, 3'b000};
      end
      SZ_H: begin
        mask = 32'h0000_FFFF << {addr[1], 4'b0000};
        ins  = {16'h0, wdata[15:0]} << {addr[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wdata;
      end
    endcase
    return (word & ~mask) | ins;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational load extraction and store merge
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  assign load_data  = lane_extract(word, addr, size, uns);
  assign store_word = lane_merge(word, addr, size, wdata);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store initiator for the dual-port data RAM
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [1:0]              REQ_SIZE,
  input  logic                    REQ_UNSIGNED,
  input  logic [addr_width+1:0]   REQ_ADDR,
  input  logic [31:0]             REQ_WDATA,
  output logic                    RSP_VALID,
  output logic [31:0]             RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [addr_width-1:0]   ADRR_R,
  output logic                    ENABLE_R,
  input  logic [data_width-1:0]   Q_R,
  output logic [addr_width-1:0]   ADRR_W,
  output logic                    ENABLE_W,
  output logic [data_width-1:0]   Q_W
);

  state_t state, state_next;

  // Request fields captured at accept so later input changes are ignored.
  logic                  lat_we;
  logic [1:0]            lat_size;
  logic                  lat_uns;
  logic [addr_width+1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic                  lat_load;

  // Next values for every registered output.
  logic                  ready_d;
  logic                  rsp_valid_d;
  logic [31:0]           rsp_rdata_d;
  logic                  rsp_err_d;
  logic [addr_width-1:0] adrr_r_d;
  logic                  enable_r_d;
  logic [addr_width-1:0] adrr_w_d;
  logic                  enable_w_d;
  logic [data_width-1:0] q_w_d;

  logic [31:0]           load_data;
  logic [31:0]           store_word;

  // Read data always arrives in RD_WAIT, where the latched request picks the lane.
  mem_lane_align u_align (
    .word       (Q_R),
    .addr       (lat_addr[1:0]),
    .size       (lat_size),
    .uns        (lat_uns),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and next output values; addresses and write data hold by default.
  always_comb begin
    state_next  = state;
    lat_load    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    adrr_r_d    = ADRR_R;
    enable_r_d  = 1'b0;
    adrr_w_d    = ADRR_W;
    enable_w_d  = 1'b0;
    q_w_d       = Q_W;
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          lat_load = 1'b1;
          if (is_misaligned(REQ_SIZE, REQ_ADDR[1:0])) begin
            state_next  = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (REQ_WE && (REQ_SIZE == SZ_W)) begin
            state_next = WR;
            enable_w_d = 1'b1;
            adrr_w_d   = REQ_ADDR[addr_width+1:2];
            q_w_d      = REQ_WDATA;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_next = RD;
            enable_r_d = 1'b1;
            adrr_r_d   = REQ_ADDR[addr_width+1:2];
          end
        end
      end
      RD: state_next = RD_WAIT;
      RD_WAIT: begin
        if (lat_we) begin
          state_next = WR;
          enable_w_d = 1'b1;
          adrr_w_d   = lat_addr[addr_width+1:2];
          q_w_d      = store_word;
        end else begin
          state_next  = RSP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      WR: begin
        state_next  = RSP;
        rsp_valid_d = 1'b1;
      end
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ready_d = (state_next == IDLE);
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 32'h0;
      RSP_ERR   <= 1'b0;
      ADRR_R    <= '0;
      ENABLE_R  <= 1'b0;
      ADRR_W    <= '0;
      ENABLE_W  <= 1'b0;
      Q_W       <= '0;
    end else begin
      REQ_READY <= ready_d;
      RSP_VALID <= rsp_valid_d;
      RSP_RDATA <= rsp_rdata_d;
      RSP_ERR   <= rsp_err_d;
      ADRR_R    <= adrr_r_d;
      ENABLE_R  <= enable_r_d;
      ADRR_W    <= adrr_w_d;
      ENABLE_W  <= enable_w_d;
      Q_W       <= q_w_d;
    end
  end

  // Request capture on accept.
  always_ff @(posedge CLK) begin
    if (lat_load) begin
      lat_we    <= REQ_WE;
      lat_size  <= REQ_SIZE;
      lat_uns   <= REQ_UNSIGNED;
      lat_addr  <= REQ_ADDR;
      lat_wdata <= REQ_WDATA;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural RAM
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
  logic [1:0]  REQ_SIZE;
  logic [11:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic [9:0]  ADRR_R, ADRR_W;
  logic        ENABLE_R, ENABLE_W;
  logic [31:0] Q_R, Q_W;

  always #10 CLK = ~CLK;

  mem_access_unit #(.addr_width(10), .data_width(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE),
    .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .ADRR_R(ADRR_R), .ENABLE_R(ENABLE_R), .Q_R(Q_R),
    .ADRR_W(ADRR_W), .ENABLE_W(ENABLE_W), .Q_W(Q_W)
  );

  // RAM: registered read, write on enable, never reset (clr only zeroes it at start).
  logic [31:0] ram [0:1023];
  logic        clr = 1'b1;
  always @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
    end else begin
      if (ENABLE_W) ram[ADRR_W] <= Q_W;
      if (ENABLE_R) Q_R <= ram[ADRR_R];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  // Reference memory as a byte array, little-endian.
  logic [7:0] ref_mem [0:4095];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          k;
    int          nr;
    int          nw;
    logic [9:0]  widx;
    logic [31:0] wword;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int last_rsp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks RAM traffic against the in-flight request and pops on each response.
  initial begin
    int rc, wc;
    exp_t e;
    rc = 0;
    wc = 0;
    forever begin
      @(negedge CLK);
      if (ENABLE_R || ENABLE_W) chk("en_exclusive", {31'b0, ENABLE_R & ENABLE_W}, 32'h0);
      if (ENABLE_R) begin
        rc++;
        if (sb.size() > 0) chk("adrr_r", {22'b0, ADRR_R}, {22'b0, sb[0].widx});
      end
      if (ENABLE_W) begin
        wc++;
        if (sb.size() > 0) begin
          chk("adrr_w", {22'b0, ADRR_W}, {22'b0, sb[0].widx});
          chk("q_w", Q_W, sb[0].wword);
        end
      end
      if (RSP_VALID) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got RSP_VALID=1 expected no response");
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", RSP_RDATA, e.rdata);
          chk("rsp_err", {31'b0, RSP_ERR}, {31'b0, e.err});
          chk("latency", 32'(cyc - e.k), 32'(e.lat));
          chk("read_pulses", 32'(rc), 32'(e.nr));
          chk("write_pulses", 32'(wc), 32'(e.nw));
        end
        last_rsp = cyc;
        rc = 0;
        wc = 0;
      end else if (REQ_READY) begin
        rc = 0;
        wc = 0;
      end
    end
  end

  // Present one request, wait for accept, record expectations from the byte model.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input bit track, input bit hold, output int k);
    exp_t e;
    int nb, w;
    logic [31:0] v, m;
    logic [11:0] base;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_UNSIGNED = uns;
    REQ_ADDR = addr; REQ_WDATA = wdata;
    w = 0;
    k = -1;
    while (!REQ_READY && w <= 20) begin
      @(negedge CLK);
      w++;
    end
    if (!REQ_READY) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got REQ_READY=0 after %0d cycles expected 1", w);
      REQ_VALID = 1'b0;
      return;
    end
    k = cyc;
    nb = 1 << size;
    base = {addr[11:2], 2'b00};
    e.k = k; e.rdata = 32'h0; e.widx = addr[11:2]; e.wword = 32'h0; e.nr = 0; e.nw = 0;
    e.err = (size == 2'b11) || ((addr % nb) != 0);
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (nb < 4 && !uns && v[8 * nb - 1]) begin
        m = (32'h1 << (8 * nb)) - 32'h1;
        v = v | ~m;
      end
      e.rdata = v; e.lat = 3; e.nr = 1;
    end else begin
      if (track) for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8 * i +: 8];
      for (int i = 0; i < 4; i++) e.wword[8 * i +: 8] = ref_mem[base + i];
      e.lat = (nb == 4) ? 2 : 4;
      e.nr  = (nb == 4) ? 0 : 1;
      e.nw  = 1;
    end
    if (track) sb.push_back(e);
    @(negedge CLK);
    if (!hold) begin
      REQ_VALID = 1'b0;
      REQ_WE = 1'($urandom); REQ_SIZE = 2'($urandom); REQ_UNSIGNED = 1'($urandom);
      REQ_ADDR = 12'($urandom); REQ_WDATA = $urandom;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int k, prev;
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
    REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00; REQ_UNSIGNED = 1'b0;
    REQ_ADDR = 12'h0; REQ_WDATA = 32'h0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    clr = 1'b0;

    chk("reset_ready", {31'b0, REQ_READY}, 32'h1);
    chk("reset_rsp_valid", {31'b0, RSP_VALID}, 32'h0);
    chk("reset_rsp_rdata", RSP_RDATA, 32'h0);
    chk("reset_rsp_err", {31'b0, RSP_ERR}, 32'h0);
    chk("reset_enable_r", {31'b0, ENABLE_R}, 32'h0);
    chk("reset_enable_w", {31'b0, ENABLE_W}, 32'h0);
    chk("reset_adrr_r", {22'b0, ADRR_R}, 32'h0);
    chk("reset_adrr_w", {22'b0, ADRR_W}, 32'h0);
    chk("reset_q_w", Q_W, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 12'h008, 32'hDEADBEEF, 1, 0, k);
    issue(1'b0, 2'b00, 1'b0, 12'h00B, 32'h0, 1, 0, k);
    issue(1'b0, 2'b00, 1'b1, 12'h00B, 32'h0, 1, 0, k);
    issue(1'b0, 2'b01, 1'b0, 12'h00A, 32'h0, 1, 0, k);
    issue(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, 1, 0, k);
    issue(1'b1, 2'b00, 1'b0, 12'h009, 32'h00000055, 1, 0, k);
    issue(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, 1, 0, k);
    issue(1'b0, 2'b10, 1'b0, 12'h006, 32'h0, 1, 0, k);
    issue(1'b1, 2'b01, 1'b0, 12'h003, 32'hCAFE, 1, 0, k);
    issue(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, 1, 0, k);
    issue(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 1, 0, k);
    drain();

    // Sub-word store aborted by reset while waiting on read data.
    issue(1'b1, 2'b01, 1'b0, 12'h00A, 32'h1234, 0, 0, k);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_ready", {31'b0, REQ_READY}, 32'h1);
    chk("abort_enable_w", {31'b0, ENABLE_W}, 32'h0);
    chk("abort_rsp_valid", {31'b0, RSP_VALID}, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, 1, 0, k);
    drain();

    // Back-to-back with REQ_VALID held high.
    issue(1'b1, 2'b10, 1'b0, 12'h3FC, 32'h13579BDF, 1, 1, k);
    for (int i = 1; i < 4; i++) begin
      prev = last_rsp;
      issue(i[0] ? 1'b0 : 1'b1, 2'b10, 1'b0, 12'h3FC, 32'h2468ACE0 + 32'(i), 1, (i < 3), k);
      chk("b2b_accept_cycle", 32'(k), 32'(last_rsp + 1));
      if (prev == last_rsp) chk("b2b_rsp_seen", 32'(last_rsp), 32'(prev + 1));
    end
    drain();

    // Random traffic concentrated on a few words so merges interact.
    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63)) : 12'($urandom_range(12'hFC0, 12'hFFF));
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
            1, (n < 199) && ($urandom_range(0, 3) == 0), k);
    end
    REQ_VALID = 1'b0;
    drain();
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
